// File: rtl/extract_dispatcher_pkg.sv
// Shared types and sizing for the header-extraction dispatcher and its helpers.
// The lane index width is the log2 of the lane count.
package extract_dispatcher_pkg;
    localparam int NUM_LANES = 8;
    localparam int LANE_W    = 3;
    localparam int DATA_W    = 32;
    localparam int CNT_W     = 16;

    typedef enum logic {IDLE, STREAM} state_t;

    typedef logic [LANE_W-1:0]    lane_idx_t;
    typedef logic [NUM_LANES-1:0] lane_mask_t;

    function automatic lane_mask_t laneOneHot(lane_idx_t idx);
        lane_mask_t m;
        m      = '0;
        m[idx] = 1'b1;
        return m;
    endfunction
endpackage

// File: rtl/extract_dispatcher_if.sv
// Framed header-word stream (sop/eop) with a valid/ready handshake.
interface extract_dispatcher_if;
    import extract_dispatcher_pkg::*;

    logic              hdr_valid;
    logic [DATA_W-1:0] hdr_data;
    logic              hdr_sop;
    logic              hdr_eop;
    logic              hdr_ready;

    modport master (output hdr_valid, hdr_data, hdr_sop, hdr_eop, input hdr_ready);
    modport slave  (input hdr_valid, hdr_data, hdr_sop, hdr_eop, output hdr_ready);
endinterface

// File: rtl/extract_dispatcher_rr_free_picker.sv
// Round-robin pick of the first set bit of a free mask, starting at ptr.
// Purely combinational so the merge arbiter can reuse it.
module rr_free_picker #(
    parameter int N = 8,
    parameter int W = 3
) (
    input  logic [N-1:0] freeMask,
    input  logic [W-1:0] ptr,
    output logic         grantValid,
    output logic [W-1:0] grantIdx
);
    int idx;

    // Walk from farthest to nearest so the slot closest to ptr wins.
    always_comb begin
        grantValid = 1'b0;
        grantIdx   = '0;
        idx        = 0;
        for (int k = N - 1; k >= 0; k--) begin
            idx = (int'(ptr) + k) % N;
            if (freeMask[idx]) begin
                grantValid = 1'b1;
                grantIdx   = W'(idx);
            end
        end
    end
endmodule

// File: rtl/extract_dispatcher.sv
// Assigns each framed header packet to a free extraction lane, round-robin,
// and keeps that lane busy until it reports completion.
module extract_dispatcher
    import extract_dispatcher_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset,
    extract_dispatcher_if.slave    hdr,
    input  logic [NUM_LANES-1:0]   lane_done,
    output logic [NUM_LANES-1:0]   lane_valid,
    output logic [DATA_W-1:0]      lane_data,
    output logic                   lane_sop,
    output logic                   lane_eop,
    output logic [LANE_W-1:0]      lane_id,
    output logic [NUM_LANES-1:0]   busy,
    output logic                   sop_err,
    output logic [CNT_W-1:0]       pkt_cnt
);
    state_t     state;
    lane_idx_t  rrPtr;
    lane_idx_t  lockLane;
    logic       pendingDone;

    logic       grantValid;
    lane_idx_t  grantIdx;
    lane_mask_t freeMask;

    logic       accept;
    logic       grant;
    logic       fwdBeat;
    logic       eopAccept;
    logic       dropBeat;
    logic       lockDone;
    lane_mask_t doneEff;
    lane_mask_t busyClr;
    lane_mask_t busySet;

    assign freeMask = ~busy;

    rr_free_picker #(.N(NUM_LANES), .W(LANE_W)) uPicker (
        .freeMask   (freeMask),
        .ptr        (rrPtr),
        .grantValid (grantValid),
        .grantIdx   (grantIdx)
    );

    // A new sop only stalls when no lane can take it; stray beats are always sunk.
    assign hdr.hdr_ready = (state == STREAM) || !hdr.hdr_sop || grantValid;

    assign accept    = hdr.hdr_valid && hdr.hdr_ready;
    assign grant     = accept && (state == IDLE) && hdr.hdr_sop;
    assign fwdBeat   = accept && (state == STREAM) && !hdr.hdr_sop;
    assign eopAccept = fwdBeat && hdr.hdr_eop;
    assign dropBeat  = accept && ((state == IDLE) != hdr.hdr_sop);

    // The lane still being fed must stay owned until its eop goes out,
    // even if it reports done early; that done is held in pendingDone.
    always_comb begin
        doneEff  = lane_done & busy;
        lockDone = (state == STREAM) && doneEff[lockLane];
        busyClr  = doneEff;
        if (state == STREAM)
            busyClr[lockLane] = 1'b0;
        if (eopAccept && (pendingDone || lockDone))
            busyClr[lockLane] = 1'b1;
        busySet = grant ? laneOneHot(grantIdx) : '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            rrPtr       <= '0;
            lockLane    <= '0;
            pendingDone <= 1'b0;
            busy        <= '0;
            lane_valid  <= '0;
            lane_data   <= '0;
            lane_sop    <= 1'b0;
            lane_eop    <= 1'b0;
            lane_id     <= '0;
            sop_err     <= 1'b0;
            pkt_cnt     <= '0;
        end else begin
            busy        <= (busy & ~busyClr) | busySet;
            sop_err     <= dropBeat;
            pendingDone <= (state == STREAM) && !eopAccept && (pendingDone || lockDone);
            lane_valid  <= '0;
            lane_sop    <= 1'b0;
            lane_eop    <= 1'b0;

            case (state)
                IDLE: begin
                    if (grant) begin
                        lane_valid <= laneOneHot(grantIdx);
                        lane_data  <= hdr.hdr_data;
                        lane_sop   <= 1'b1;
                        lane_eop   <= hdr.hdr_eop;
                        lane_id    <= grantIdx;
                        lockLane   <= grantIdx;
                        rrPtr      <= grantIdx + lane_idx_t'(1);
                        pkt_cnt    <= pkt_cnt + CNT_W'(1);
                        state      <= hdr.hdr_eop ? IDLE : STREAM;
                    end
                end
                STREAM: begin
                    if (fwdBeat) begin
                        lane_valid <= laneOneHot(lockLane);
                        lane_data  <= hdr.hdr_data;
                        lane_eop   <= hdr.hdr_eop;
                        lane_id    <= lockLane;
                        if (hdr.hdr_eop)
                            state <= IDLE;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_extract_dispatcher.sv
// Scoreboard bench for extract_dispatcher: a packet-level model predicts each
// lane beat / drop, a monitor pops and compares one cycle after acceptance.
module tb_extract_dispatcher;
    import extract_dispatcher_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  lane_done, doneDir, doneRnd;
    logic [7:0]  lane_valid, busy;
    logic [31:0] lane_data;
    logic        lane_sop, lane_eop, sop_err;
    logic [2:0]  lane_id;
    logic [15:0] pkt_cnt;
    bit          rndEn = 1'b0;
    bit          ok;
    int          checks = 0;
    int          errors = 0;

    extract_dispatcher_if hdr();

    assign lane_done = doneDir | doneRnd;

    extract_dispatcher dut (
        .clk(clk), .reset(reset), .hdr(hdr), .lane_done(lane_done),
        .lane_valid(lane_valid), .lane_data(lane_data), .lane_sop(lane_sop),
        .lane_eop(lane_eop), .lane_id(lane_id), .busy(busy), .sop_err(sop_err),
        .pkt_cnt(pkt_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  v;
        logic [31:0] d;
        logic        s;
        logic        e;
        logic        err;
        logic [2:0]  id;
    } exp_t;
    exp_t expQ[$];

    // Packet-level model: which lanes own a packet, which packet is open.
    logic [7:0]  mOwned;
    int          mRr, mCur;
    bit          mIn, mEarly;
    logic [15:0] mCnt;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic bit mReady();
        return mIn || !hdr.hdr_sop || (mOwned != 8'hFF);
    endfunction

    task automatic modelStep();
        logic [7:0] nOwned, dn;
        bit wasIn, finish;
        int cur, L;
        if (reset) begin
            mOwned = '0; mRr = 0; mIn = 0; mCur = 0; mEarly = 0; mCnt = '0;
            expQ.delete();
            return;
        end
        nOwned = mOwned;
        dn     = lane_done & mOwned;
        wasIn  = mIn;
        cur    = mCur;
        finish = 0;
        if (hdr.hdr_valid && mReady()) begin
            if (!wasIn && hdr.hdr_sop) begin
                L = 0;
                for (int k = 7; k >= 0; k--)
                    if (!mOwned[(mRr + k) % 8]) L = (mRr + k) % 8;
                nOwned[L] = 1'b1;
                mRr  = (L + 1) % 8;
                mCnt = mCnt + 16'd1;
                expQ.push_back('{v: 8'(1) << L, d: hdr.hdr_data, s: 1'b1,
                                 e: hdr.hdr_eop, err: 1'b0, id: 3'(L)});
                if (!hdr.hdr_eop) begin
                    mIn = 1; mCur = L; mEarly = 0;
                end
            end else if (wasIn && !hdr.hdr_sop) begin
                expQ.push_back('{v: 8'(1) << cur, d: hdr.hdr_data, s: 1'b0,
                                 e: hdr.hdr_eop, err: 1'b0, id: 3'(cur)});
                finish = hdr.hdr_eop;
            end else begin
                expQ.push_back('{v: 8'h0, d: 32'h0, s: 1'b0, e: 1'b0, err: 1'b1, id: 3'h0});
            end
        end
        for (int i = 0; i < 8; i++)
            if (dn[i]) begin
                if (wasIn && i == cur) mEarly = 1;
                else nOwned[i] = 1'b0;
            end
        if (finish) begin
            if (mEarly) nOwned[cur] = 1'b0;
            mIn = 0; mEarly = 0;
        end
        mOwned = nOwned;
    endtask

    initial forever begin
        @(posedge clk);
        modelStep();
    end

    // Monitor: every cycle, whatever the model predicted for this edge must show up.
    initial forever begin
        exp_t e;
        @(posedge clk); #1;
        if (expQ.size() != 0) begin
            e = expQ.pop_front();
            chk("lane_valid", lane_valid, e.v);
            chk("sop_err", sop_err, e.err);
            if (!e.err) begin
                chk("lane_data", lane_data, e.d);
                chk("lane_sop", lane_sop, e.s);
                chk("lane_eop", lane_eop, e.e);
                chk("lane_id", lane_id, e.id);
            end
        end else begin
            chk("idle_valid", lane_valid, 0);
            chk("idle_err", sop_err, 0);
        end
        chk("busy", busy, mOwned);
        chk("pkt_cnt", pkt_cnt, mCnt);
    end

    initial forever begin
        @(posedge clk); #4;
        if (!reset) chk("hdr_ready", hdr.hdr_ready, mReady());
    end

    initial forever begin
        @(posedge clk); #2;
        doneRnd = (rndEn && $urandom_range(0, 3) == 0) ? (8'h1 << $urandom_range(0, 7)) : 8'h0;
    end

    task automatic tick();
        @(posedge clk); #2;
    endtask

    task automatic beat(input logic [31:0] d, input logic s, input logic e, output bit acc);
        logic rdy;
        hdr.hdr_valid = 1'b1; hdr.hdr_data = d; hdr.hdr_sop = s; hdr.hdr_eop = e;
        acc = 0;
        for (int n = 0; n < 200; n++) begin
            #2; rdy = hdr.hdr_ready;
            @(posedge clk); #2;
            if (rdy) begin acc = 1; break; end
        end
        hdr.hdr_valid = 1'b0;
        if (!acc) begin
            checks++; errors++;
            $display("FAIL beat_timeout got stalled want accepted data %0h", d);
        end
    endtask

    task automatic pulseDone(input logic [7:0] m);
        doneDir = m; tick(); doneDir = 8'h0;
    endtask

    task automatic rstPulse();
        reset = 1'b1; tick(); reset = 1'b0;
    endtask

    initial begin
        int len;
        reset = 1'b1; doneDir = 8'h0; doneRnd = 8'h0;
        hdr.hdr_valid = 1'b0; hdr.hdr_data = '0; hdr.hdr_sop = 1'b0; hdr.hdr_eop = 1'b0;
        repeat (2) @(posedge clk); #2;
        chk("rst_valid", lane_valid, 0); chk("rst_id", lane_id, 0);
        chk("rst_data", lane_data, 0);   chk("rst_sop", lane_sop, 0);
        chk("rst_eop", lane_eop, 0);     chk("rst_err", sop_err, 0);
        chk("rst_busy", busy, 0);        chk("rst_cnt", pkt_cnt, 0);
        reset = 1'b0;

        // Three single-beat packets land on lanes 0,1,2.
        beat(32'hA0, 1, 1, ok); beat(32'hA1, 1, 1, ok); beat(32'hA2, 1, 1, ok);
        chk("s1_valid", lane_valid, 8'h04); chk("s1_id", lane_id, 2);
        chk("s1_busy", busy, 8'h07);        chk("s1_cnt", pkt_cnt, 3);
        pulseDone(8'hFF);
        chk("s1_free", busy, 8'h00);
        beat(32'hB0, 1, 1, ok);
        chk("s1_rr", lane_id, 3);

        // Four-word packet on a freshly reset block.
        rstPulse();
        beat(32'h10, 1, 0, ok); chk("s2_v0", lane_valid, 8'h01); chk("s2_sop", lane_sop, 1);
        beat(32'h11, 0, 0, ok); chk("s2_v1", lane_valid, 8'h01);
        beat(32'h12, 0, 0, ok); chk("s2_v2", lane_valid, 8'h01);
        beat(32'h13, 0, 1, ok); chk("s2_v3", lane_valid, 8'h01); chk("s2_eop", lane_eop, 1);
        pulseDone(8'h01);

        // Fill every lane, stall a ninth sop until lane 5 completes.
        for (int i = 0; i < 8; i++) beat(32'hC0 + i, 1, 1, ok);
        chk("s3_full", busy, 8'hFF);
        fork
            beat(32'hC8, 1, 1, ok);
            begin repeat (3) tick(); pulseDone(8'h20); end
        join
        chk("s3_lane5", lane_id, 5); chk("s3_valid", lane_valid, 8'h20);
        pulseDone(8'hFF);

        // Locked lane reports done mid-packet; ownership holds until eop.
        beat(32'hD0, 1, 0, ok);
        pulseDone(8'h40);
        chk("s4_hold", busy, 8'h40);
        beat(32'hD1, 0, 0, ok); chk("s4_hold2", busy, 8'h40);
        beat(32'hD2, 0, 1, ok); chk("s4_clear", busy, 8'h00);

        // Stray beats in both states.
        beat(32'h55, 0, 0, ok); chk("s5_err0", sop_err, 1); chk("s5_v0", lane_valid, 0);
        beat(32'hF0, 1, 0, ok);
        beat(32'h66, 1, 1, ok); chk("s5_err1", sop_err, 1); chk("s5_v1", lane_valid, 0);
        beat(32'hF1, 0, 1, ok); chk("s5_tail", lane_valid, 8'h80); chk("s5_eop", lane_eop, 1);
        pulseDone(8'hFF);

        // Reset in the middle of a packet.
        beat(32'h70, 1, 0, ok); beat(32'h71, 0, 0, ok);
        reset = 1'b1; tick();
        chk("s6_valid", lane_valid, 0); chk("s6_busy", busy, 0);
        chk("s6_cnt", pkt_cnt, 0);      chk("s6_data", lane_data, 0);
        chk("s6_id", lane_id, 0);       chk("s6_sop", lane_sop, 0);
        chk("s6_eop", lane_eop, 0);
        reset = 1'b0;
        beat(32'h80, 1, 1, ok); chk("s6_lane0", lane_valid, 8'h01);

        // Random traffic with random completions.
        rndEn = 1'b1;
        for (int p = 0; p < 250; p++) begin
            len = $urandom_range(1, 4);
            if ($urandom_range(0, 9) == 0) beat($urandom, 0, 1'($urandom_range(0, 1)), ok);
            for (int w = 0; w < len; w++) begin
                beat($urandom, w == 0, w == len - 1, ok);
                if (len > 2 && w == 1 && $urandom_range(0, 7) == 0)
                    beat($urandom, 1, 1'($urandom_range(0, 1)), ok);
                repeat ($urandom_range(0, 1)) tick();
            end
        end
        rndEn = 1'b0;
        pulseDone(8'hFF);
        repeat (3) tick();
        chk("queue_empty", expQ.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
